// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the ifu/lsu SRAM arbiter.
// Starvation relief is enabled by defining MEM_ARB_STARVE_EN.
package mem_pkg;

    localparam int unsigned ADDR_W         = 14;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BADDR_W        = 16;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } rd_own_t;

endpackage

// File: rtl/mem_arb_if.sv
// Request, return and SRAM bus bundle for mem_arb.
// slave = arbiter side, master = requesters and SRAM macro side.
interface mem_arb_if;
    import mem_pkg::*;

    logic                ins_e;
    logic [BADDR_W-1:0]  ins_a;
    logic                ins_gnt;
    logic                ins_vld;
    logic [DATA_W-1:0]   ins;

    logic                dat_re;
    logic [3:0]          dat_we;
    logic [BADDR_W-1:0]  dat_a;
    logic [DATA_W-1:0]   dat_wd;
    logic                dat_gnt;
    logic                dat_vld;
    logic [DATA_W-1:0]   dat_rd;

    logic                sram_e;
    logic [3:0]          sram_we;
    logic [ADDR_W-1:0]   sram_a;
    logic [DATA_W-1:0]   sram_wd;
    logic [DATA_W-1:0]   sram_o;

    modport slave (
        input  ins_e, ins_a, dat_re, dat_we, dat_a, dat_wd, sram_o,
        output ins_gnt, ins_vld, ins, dat_gnt, dat_vld, dat_rd,
               sram_e, sram_we, sram_a, sram_wd
    );

    modport master (
        output ins_e, ins_a, dat_re, dat_we, dat_a, dat_wd, sram_o,
        input  ins_gnt, ins_vld, ins, dat_gnt, dat_vld, dat_rd,
               sram_e, sram_we, sram_a, sram_wd
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Combinational grant decision (lsu over ifu) for mem_arb.
// With MEM_ARB_STARVE_EN, a denial counter forces an ifu grant at STARVE_MAX.
module mem_arb_prio
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ins_req,
    input  logic dat_req,
    output logic ins_gnt,
    output logic dat_gnt
);

    logic force_ifu;

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    assign force_ifu = ins_req && (starve_cnt == 4'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (ins_gnt) begin
            starve_cnt <= '0;
        end else if (ins_req) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    logic starve_unused;

    assign force_ifu     = 1'b0;
    assign starve_unused = ^{clk, 4'(STARVE_MAX)};
`endif

    always_comb begin
        ins_gnt = 1'b0;
        dat_gnt = 1'b0;
        if (!rst) begin
            if (force_ifu) begin
                ins_gnt = 1'b1;
            end else if (dat_req) begin
                dat_gnt = 1'b1;
            end else if (ins_req) begin
                ins_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Single-port SRAM arbiter between ifu reads and lsu reads/writes, 1-cycle read return.
// Optional starvation relief for ifu under MEM_ARB_STARVE_EN (see mem_arb_prio).
module mem_arb
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mem_arb_if.slave   bus
);

    logic              ins_gnt;
    logic              dat_gnt;
    logic              dat_req;
    rd_own_t           rd_own;
    rd_own_t           rd_own_nxt;
    logic [DATA_W-1:0] ins_q;
    logic [DATA_W-1:0] dat_q;
    logic              addr_unused;

    assign dat_req     = bus.dat_re || (|bus.dat_we);
    assign addr_unused = ^{bus.ins_a[1:0], bus.dat_a[1:0]};

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .ins_req (bus.ins_e),
        .dat_req (dat_req),
        .ins_gnt (ins_gnt),
        .dat_gnt (dat_gnt)
    );

    assign bus.ins_gnt = ins_gnt;
    assign bus.dat_gnt = dat_gnt;

    always_comb begin
        bus.sram_e  = ins_gnt || dat_gnt;
        bus.sram_we = '0;
        bus.sram_a  = '0;
        bus.sram_wd = bus.dat_wd;
        if (dat_gnt) begin
            bus.sram_we = bus.dat_we;
            bus.sram_a  = bus.dat_a[15:2];
        end else if (ins_gnt) begin
            bus.sram_a  = bus.ins_a[15:2];
        end
    end

    // A combined read+write from lsu is treated as a write: no return owner.
    always_comb begin
        rd_own_nxt = OWN_NONE;
        if (dat_gnt) begin
            rd_own_nxt = (bus.dat_we == 4'b0000) ? OWN_LSU : OWN_NONE;
        end else if (ins_gnt) begin
            rd_own_nxt = OWN_IFU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_own <= OWN_NONE;
            ins_q  <= '0;
            dat_q  <= '0;
        end else begin
            rd_own <= rd_own_nxt;
            if (rd_own == OWN_IFU) ins_q <= bus.sram_o;
            if (rd_own == OWN_LSU) dat_q <= bus.sram_o;
        end
    end

    // Return data is bypassed from sram_o during the pulse, then held in the register.
    assign bus.ins_vld = !rst && (rd_own == OWN_IFU);
    assign bus.dat_vld = !rst && (rd_own == OWN_LSU);
    assign bus.ins     = rst ? '0 : (bus.ins_vld ? bus.sram_o : ins_q);
    assign bus.dat_rd  = rst ? '0 : (bus.dat_vld ? bus.sram_o : dat_q);

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive ifu denials before a forced ifu grant; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 ins_e  in  1  ifu read request; held stable until granted.
REQ-005 ins_a  in  16  ifu byte address; bits [15:2] are used.
REQ-006 ins_gnt  out  1  ifu request accepted this cycle.
REQ-007 ins_vld  out  1  one-cycle pulse: ins carries the granted read data.
REQ-008 ins  out  32  ifu read data; holds its value between pulses.
REQ-009 dat_re  in  1  lsu read request.
REQ-010 dat_we  in  4  lsu byte write enables; nonzero means write request.
REQ-011 dat_a  in  16  lsu byte address; bits [15:2] are used.
REQ-012 dat_wd  in  32  lsu write data.
REQ-013 dat_gnt  out  1  lsu request accepted this cycle.
REQ-014 dat_vld  out  1  one-cycle pulse: dat_rd carries the granted read data.
REQ-015 dat_rd  out  32  lsu read data; holds its value between pulses.
REQ-016 sram_e  out  1  SRAM access enable.
REQ-017 sram_we  out  4  SRAM byte write enables.
REQ-018 sram_a  out  14  SRAM word address.
REQ-019 sram_wd  out  32  SRAM write data.
REQ-020 sram_o  in  32  SRAM read data, valid one cycle after the access.

Function
REQ-021 The block arbitrates one single-port SRAM between ifu and lsu; at most one grant is issued per cycle.
REQ-022 Grant logic is combinational.
  - Default priority: lsu over ifu.
  - An lsu request is dat_re or any dat_we bit set.
REQ-023 SRAM drive follows the winner in the same cycle.
  - sram_e = 1; sram_a = winner address[15:2].
  - sram_we = dat_we if lsu wins, 0 if ifu wins.
  - sram_wd = dat_wd.
  - With no winner: sram_e = 0, sram_we = 0, sram_a = 0.
REQ-024 If dat_re and dat_we are both set, the block performs the write only; no dat_vld is produced.
REQ-025 A read granted in cycle N produces the owner's vld pulse in cycle N+1.
  - The owner (ifu, lsu or none) is kept in a registered field, rd_own.
  - In cycle N+1 the owner's data register is loaded from sram_o.
  - Latency is exactly 1 cycle; back-to-back grants give vld on consecutive cycles.
REQ-026 A granted write produces no vld pulse and leaves rd_own = none.
REQ-027 The ungranted requester sees gnt = 0 and must hold its request; nothing is dropped or queued internally.

Reset
REQ-028 While rst = 1:
  - ins_gnt, dat_gnt, ins_vld, dat_vld, sram_e and sram_we are all 0.
  - ins = 0, dat_rd = 0, rd_own = none, starvation counter = 0.
REQ-029 If rst asserts in the cycle after a read grant, that read's vld pulse is suppressed.
REQ-030 The first grant is possible in the first cycle with rst = 0.

Configuration
REQ-031 Macro MEM_ARB_STARVE_EN.
  - When defined: a 4-bit counter increments on each cycle with ins_e = 1 and ins_gnt = 0, and clears on ins_gnt.
  - When the counter equals STARVE_MAX, ifu wins that cycle even if lsu is requesting.
  - When undefined: the counter is absent and strict lsu priority applies; ifu may starve.

Structure
REQ-032 A shared package mem_pkg holds:
  - the rd_own enum (OWN_NONE, OWN_IFU, OWN_LSU);
  - address width 14 and data width 32;
  - the STARVE_MAX default.
REQ-033 One sub-module, mem_arb_prio, contains the combinational grant decision and, under the macro, the starvation counter; the datapath and return registers live in mem_arb. Target size is 120-400 lines of RTL.

Verification
REQ-034 Scenario 1: ifu read only, ins_a=0x0010, sram_o=0xDEADBEEF in the next cycle.
  - ins_gnt=1 and sram_a=0x004.
  - Next cycle: ins_vld=1 and ins=0xDEADBEEF.
REQ-035 Scenario 2: ins_e and dat_re both held for 3 cycles, lsu address 0x0100.
  - Without the macro: dat_gnt=1 for 3 cycles and ins_gnt=0.
  - dat_vld pulses in cycles 2-4.
REQ-036 Scenario 3: with MEM_ARB_STARVE_EN and STARVE_MAX=4, ins_e and dat_re both held for 6 cycles.
  - ins_gnt=1 in cycle 5 only.
  - The counter returns to 0 after that grant.
REQ-037 Scenario 4: dat_we=4'b0011, dat_re=1, dat_a=0x0008, dat_wd=0x12345678.
  - sram_we=4'b0011 and sram_a=0x002.
  - No dat_vld in the next cycle.
REQ-038 Scenario 5: an ifu read is granted and rst=1 in the following cycle.
  - ins_vld stays 0 and ins=0.
  - All outputs are at their reset values.
REQ-039 Scenario 6: alternate ifu/lsu reads on consecutive cycles.
  - Each vld pulse routes sram_o to the correct port.
  - The other port's data is unchanged.
